// File: rtl/uart_rx_deser.sv
// uart_rx_deser: UART serial receive front end.
//
// Oversamples the asynchronous rx_i line with a programmable bit-period
// counter, validates the start bit, and deserialises 5..8 data bits LSB
// first. It then checks the optional parity bit and the stop bit, and holds
// each completed frame on a valid/ready output register.
//
// Ports:
//   clk_i, rst_n_i         clock, asynchronous active-low reset
//   rx_i                   serial line (asynchronous, idle high)
//   cfg_en_i               receiver enable
//   cfg_div_i              bit period minus one, in clk cycles (clamped to >= 3)
//   cfg_parity_en_i        parity bit present
//   cfg_parity_sel_i       00 even, 01 odd, 10 space, 11 mark
//   cfg_bits_i             data bits minus 5
//   busy_o                 a frame is being received
//   err_o                  parity error of the held frame (sticky)
//   frm_err_o              sticky stop-bit error
//   ovr_o                  sticky overrun (frame dropped while output full)
//   err_clr_i              clear the sticky flags on a handshake
//   rx_data_o, rx_valid_o  received frame and its valid flag
//   rx_ready_i             consumer accepts the frame
module uart_rx_deser #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 rx_i,
    input  logic                 cfg_en_i,
    input  logic [DIV_WIDTH-1:0] cfg_div_i,
    input  logic                 cfg_parity_en_i,
    input  logic [1:0]           cfg_parity_sel_i,
    input  logic [1:0]           cfg_bits_i,
    output logic                 busy_o,
    output logic                 err_o,
    output logic                 frm_err_o,
    output logic                 ovr_o,
    input  logic                 err_clr_i,
    output logic [7:0]           rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i
);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sync2_q, prev_q;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 par_en_q, par_en_d;
    logic [1:0]           par_sel_q, par_sel_d;
    logic [1:0]           bits_q, bits_d;
    logic [2:0]           bitidx_q, bitidx_d;
    logic [7:0]           shreg_q, shreg_d;
    logic                 perr_q, perr_d;
    logic [7:0]           data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic                 frm_q, frm_d;
    logic                 ovr_q, ovr_d;

    logic                 fall, tick, hs, clr, done, stop_bit;

    function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [DIV_WIDTH-1:0] d);
        return (d < DIV_WIDTH'(3)) ? DIV_WIDTH'(3) : d;
    endfunction

    function automatic logic parity_expect(input logic [1:0] sel, input logic x);
        case (sel)
            2'b00:   return x;
            2'b01:   return ~x;
            2'b10:   return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    assign fall = ~sync2_q & prev_q;
    assign tick = (cnt_q == div_q);
    assign hs   = valid_q & rx_ready_i;
    assign clr  = err_clr_i & hs;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + DIV_WIDTH'(1);
        div_d     = div_q;
        par_en_d  = par_en_q;
        par_sel_d = par_sel_q;
        bits_d    = bits_q;
        bitidx_d  = bitidx_q;
        shreg_d   = shreg_q;
        perr_d    = perr_q;
        data_d    = data_q;
        valid_d   = valid_q;
        err_d     = err_q;
        frm_d     = frm_q;
        ovr_d     = ovr_q;
        done      = 1'b0;
        stop_bit  = 1'b1;

        if (hs) valid_d = 1'b0;
        if (clr) begin
            err_d = 1'b0;
            frm_d = 1'b0;
            ovr_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = cnt_q;
                if (fall && cfg_en_i) begin
                    // Counter starts at 1 so the start sample lands D>>1
                    // cycles after the detection cycle itself.
                    state_d   = S_START;
                    cnt_d     = DIV_WIDTH'(1);
                    div_d     = clamp_div(cfg_div_i);
                    par_en_d  = cfg_parity_en_i;
                    par_sel_d = cfg_parity_sel_i;
                    bits_d    = cfg_bits_i;
                    bitidx_d  = 3'd0;
                    shreg_d   = 8'h00;
                    perr_d    = 1'b0;
                end
            end
            S_START: begin
                if (cnt_q == (div_q >> 1)) begin
                    cnt_d   = '0;
                    state_d = sync2_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    cnt_d             = '0;
                    shreg_d[bitidx_q] = sync2_q;
                    bitidx_d          = bitidx_q + 3'd1;
                    if (bitidx_q == (3'd4 + {1'b0, bits_q}))
                        state_d = par_en_q ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (tick) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                    // Unused upper shift bits are zero, so XOR over all 8 is exact.
                    if (sync2_q != parity_expect(par_sel_q, ^shreg_q))
                        perr_d = 1'b1;
                end
            end
            S_STOP: begin
                if (tick) begin
                    cnt_d    = '0;
                    state_d  = S_IDLE;
                    done     = 1'b1;
                    stop_bit = sync2_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Disabling mid-frame abandons the partial frame without touching outputs.
        if (!cfg_en_i && state_q != S_IDLE) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            done    = 1'b0;
        end

        // Load step: set events override the clear applied above.
        if (done) begin
            if (!valid_q || hs) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
                err_d   = perr_q | (err_q & ~clr);
            end else begin
                ovr_d = 1'b1;
            end
            if (!stop_bit) frm_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            div_q     <= DIV_WIDTH'(3);
            par_en_q  <= 1'b0;
            par_sel_q <= 2'b00;
            bits_q    <= 2'b00;
            bitidx_q  <= 3'd0;
            shreg_q   <= 8'h00;
            perr_q    <= 1'b0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            frm_q     <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            sync1_q   <= rx_i;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            par_en_q  <= par_en_d;
            par_sel_q <= par_sel_d;
            bits_q    <= bits_d;
            bitidx_q  <= bitidx_d;
            shreg_q   <= shreg_d;
            perr_q    <= perr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            frm_q     <= frm_d;
            ovr_q     <= ovr_d;
        end
    end

    assign busy_o     = (state_q != S_IDLE);
    assign rx_data_o  = data_q;
    assign rx_valid_o = valid_q;
    assign err_o      = err_q;
    assign frm_err_o  = frm_q;
    assign ovr_o      = ovr_q;

endmodule

// File: tb/tb_uart_rx_deser.sv
module tb_uart_rx_deser;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        rx_i;
    logic        cfg_en_i;
    logic [15:0] cfg_div_i;
    logic        cfg_parity_en_i;
    logic [1:0]  cfg_parity_sel_i;
    logic [1:0]  cfg_bits_i;
    logic        busy_o, err_o, frm_err_o, ovr_o;
    logic        err_clr_i;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o;
    logic        rx_ready_i;

    uart_rx_deser #(.DIV_WIDTH(16)) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n_i),
        .rx_i             (rx_i),
        .cfg_en_i         (cfg_en_i),
        .cfg_div_i        (cfg_div_i),
        .cfg_parity_en_i  (cfg_parity_en_i),
        .cfg_parity_sel_i (cfg_parity_sel_i),
        .cfg_bits_i       (cfg_bits_i),
        .busy_o           (busy_o),
        .err_o            (err_o),
        .frm_err_o        (frm_err_o),
        .ovr_o            (ovr_o),
        .err_clr_i        (err_clr_i),
        .rx_data_o        (rx_data_o),
        .rx_valid_o       (rx_valid_o),
        .rx_ready_i       (rx_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       err;
        logic       frm;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   fall_cyc = 0;
    int   rise_cyc = -1;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake pops one expected frame.
    always @(negedge clk) begin
        if (rst_n_i === 1'b1) begin
            if (rx_valid_o && !prev_valid) rise_cyc = cyc;
            prev_valid = rx_valid_o;
            if (rx_valid_o && rx_ready_i) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame: got data %0h expected no frame", rx_data_o);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("frame_data", {24'd0, rx_data_o}, {24'd0, e.data});
                    check("frame_err", {31'd0, err_o}, {31'd0, e.err});
                    check("frame_frm", {31'd0, frm_err_o}, {31'd0, e.frm});
                end
            end
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int period();
        return ((cfg_div_i < 16'd3) ? 3 : int'(cfg_div_i)) + 1;
    endfunction

    function automatic logic xor_n(input logic [7:0] d, input int n);
        logic x = 1'b0;
        for (int i = 0; i < n; i++) x ^= d[i];
        return x;
    endfunction

    // Drives one complete frame using the current configuration.
    task automatic send(input logic [7:0] d, input logic pbit, input logic stopv, input bit chk);
        int p = period();
        int n = 5 + int'(cfg_bits_i);
        rx_i = 1'b0;
        fall_cyc = cyc;
        repeat (p) tick();
        if (chk) check("busy_start", {31'd0, busy_o}, 32'd1);
        for (int i = 0; i < n; i++) begin
            rx_i = d[i];
            repeat (p) tick();
            if (chk) check("busy_data", {31'd0, busy_o}, 32'd1);
        end
        if (cfg_parity_en_i) begin
            rx_i = pbit;
            repeat (p) tick();
        end
        rx_i = stopv;
        repeat (p) tick();
        rx_i = 1'b1;
    endtask

    task automatic push(input logic [7:0] d, input logic e, input logic f);
        exp_t x;
        x.data = d;
        x.err  = e;
        x.frm  = f;
        q.push_back(x);
    endtask

    task automatic set_cfg(input logic [15:0] dv, input logic [1:0] b, input logic pen, input logic [1:0] ps);
        cfg_div_i        = dv;
        cfg_bits_i       = b;
        cfg_parity_en_i  = pen;
        cfg_parity_sel_i = ps;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_i    = 1'b0;
        rx_i       = 1'b1;
        cfg_en_i   = 1'b1;
        err_clr_i  = 1'b1;
        rx_ready_i = 1'b1;
        set_cfg(16'd7, 2'd3, 1'b0, 2'b00);
        repeat (3) tick();
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_valid", {31'd0, rx_valid_o}, 32'd0);
        check("rst_data", {24'd0, rx_data_o}, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        check("rst_frm", {31'd0, frm_err_o}, 32'd0);
        check("rst_ovr", {31'd0, ovr_o}, 32'd0);
        rst_n_i = 1'b1;
        repeat (5) tick();

        // 8N1 basic with latency
        push(8'h55, 1'b0, 1'b0);
        send(8'h55, 1'b0, 1'b1, 1'b1);
        check("latency_8n1", rise_cyc - fall_cyc, 32'd78);
        repeat (5) tick();

        // 7E1 correct parity (0x3A has four ones -> parity bit 0)
        set_cfg(16'd7, 2'd2, 1'b1, 2'b00);
        push(8'h3A, 1'b0, 1'b0);
        send(8'h3A, 1'b0, 1'b1, 1'b1);
        repeat (5) tick();

        // 7O1 with wrong parity bit (expected 1, send 0)
        set_cfg(16'd7, 2'd2, 1'b1, 2'b01);
        push(8'h3A, 1'b1, 1'b0);
        send(8'h3A, 1'b0, 1'b1, 1'b1);
        repeat (5) tick();

        // 5-bit mark parity
        set_cfg(16'd7, 2'd0, 1'b1, 2'b11);
        push(8'h1F, 1'b0, 1'b0);
        send(8'h1F, 1'b1, 1'b1, 1'b1);
        repeat (5) tick();

        // 7E1 with odd-weight data: parity bit 1 is correct
        set_cfg(16'd7, 2'd2, 1'b1, 2'b00);
        push(8'h07, xor_n(8'h07, 7) ^ 1'b1, 1'b0);
        send(8'h07, 1'b1, 1'b1, 1'b0);
        repeat (5) tick();

        // Glitch: 2-cycle low pulse at D=15
        set_cfg(16'd15, 2'd3, 1'b0, 2'b00);
        rx_i = 1'b0;
        repeat (2) tick();
        rx_i = 1'b1;
        repeat (3) tick();
        check("glitch_detected", {31'd0, busy_o}, 32'd1);
        repeat (7) tick();
        check("glitch_idle", {31'd0, busy_o}, 32'd0);
        repeat (20) tick();

        // Framing error, frame still delivered
        set_cfg(16'd7, 2'd3, 1'b0, 2'b00);
        push(8'hC3, 1'b0, 1'b1);
        send(8'hC3, 1'b0, 1'b0, 1'b1);
        repeat (10) tick();

        // Backpressure and overrun
        rx_ready_i = 1'b0;
        err_clr_i  = 1'b0;
        push(8'h11, 1'b0, 1'b0);
        send(8'h11, 1'b0, 1'b1, 1'b0);
        repeat (3) tick();
        send(8'h22, 1'b0, 1'b1, 1'b0);
        repeat (5) tick();
        check("bp_data", {24'd0, rx_data_o}, 32'h11);
        check("bp_valid", {31'd0, rx_valid_o}, 32'd1);
        check("bp_ovr", {31'd0, ovr_o}, 32'd1);
        err_clr_i  = 1'b1;
        rx_ready_i = 1'b1;
        tick();
        check("clr_valid", {31'd0, rx_valid_o}, 32'd0);
        check("clr_ovr", {31'd0, ovr_o}, 32'd0);
        check("clr_err", {31'd0, err_o}, 32'd0);
        check("clr_frm", {31'd0, frm_err_o}, 32'd0);
        repeat (5) tick();

        // Disable after 3 data bits
        rx_i = 1'b0;
        repeat (8) tick();
        for (int i = 0; i < 3; i++) begin
            rx_i = i[0];
            repeat (8) tick();
        end
        cfg_en_i = 1'b0;
        tick();
        check("disable_idle", {31'd0, busy_o}, 32'd0);
        rx_i = 1'b1;
        repeat (60) tick();
        check("disable_no_frame", {31'd0, rx_valid_o}, 32'd0);
        cfg_en_i = 1'b1;
        repeat (5) tick();

        // Divider clamp: 0 behaves as P=4
        set_cfg(16'd0, 2'd3, 1'b0, 2'b00);
        push(8'h96, 1'b0, 1'b0);
        send(8'h96, 1'b0, 1'b1, 1'b1);
        repeat (5) tick();

        // Back-to-back frames
        set_cfg(16'd7, 2'd3, 1'b0, 2'b00);
        push(8'h00, 1'b0, 1'b0);
        push(8'hFF, 1'b0, 1'b0);
        send(8'h00, 1'b0, 1'b1, 1'b0);
        send(8'hFF, 1'b0, 1'b1, 1'b0);
        repeat (5) tick();
        check("b2b_ovr", {31'd0, ovr_o}, 32'd0);

        // Mid-frame reset with a held frame
        rx_ready_i = 1'b0;
        push(8'h5A, 1'b0, 1'b0);
        send(8'h5A, 1'b0, 1'b1, 1'b0);
        repeat (3) tick();
        rx_i = 1'b0;
        repeat (8) tick();
        rx_i = 1'b1;
        repeat (8) tick();
        rst_n_i = 1'b0;
        #1;
        check("mrst_busy", {31'd0, busy_o}, 32'd0);
        check("mrst_valid", {31'd0, rx_valid_o}, 32'd0);
        check("mrst_data", {24'd0, rx_data_o}, 32'd0);
        check("mrst_flags", {29'd0, err_o, frm_err_o, ovr_o}, 32'd0);
        q.delete();
        tick();
        rst_n_i    = 1'b1;
        rx_ready_i = 1'b1;
        repeat (10) tick();
        push(8'hA5, 1'b0, 1'b0);
        send(8'hA5, 1'b0, 1'b1, 1'b1);

        for (int i = 0; i < 200 && q.size() != 0; i++) tick();
        check("queue_drained", q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
